// File: rtl/asrv32_trace_monitor.sv
// Commit-trace capture for asrv32: timestamps register/memory writes into a FWFT trace FIFO
// and raises a sticky halt on end-address or PC-stall detection.
module asrv32_trace_monitor #(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           DEPTH       = 16,
  parameter logic [ADDR_WIDTH-1:0] END_ADDR    = 'h3C,
  parameter int unsigned           STALL_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] i_iaddr,
  input  logic                  i_rf_wr,
  input  logic [4:0]            i_rf_addr,
  input  logic [DATA_WIDTH-1:0] i_rf_data,
  input  logic                  i_mem_wr,
  input  logic [ADDR_WIDTH-1:0] i_mem_addr,
  input  logic [DATA_WIDTH-1:0] i_mem_data,
  input  logic [3:0]            i_mem_mask,
  input  logic [1:0]            i_chan_en,
  output logic                  o_trace_valid,
  input  logic                  i_trace_ready,
  output logic                  o_trace_type,
  output logic [ADDR_WIDTH-1:0] o_trace_addr,
  output logic [DATA_WIDTH-1:0] o_trace_data,
  output logic [3:0]            o_trace_mask,
  output logic [31:0]           o_trace_cycle,
  output logic [15:0]           o_drop_count,
  output logic                  o_halt,
  output logic [1:0]            o_halt_cause
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = $clog2(STALL_LIMIT + 1);

  typedef struct packed {
    logic                  typ;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [3:0]            mask;
    logic [31:0]           cycle;
  } entry_t;

  typedef enum logic {StRun, StHalted} state_e;

  state_e                r_state, w_state_next;
  logic [1:0]            r_halt_cause, w_halt_cause_next;
  entry_t                r_mem [DEPTH];
  logic [PW-1:0]         r_wr_ptr, r_rd_ptr, w_mem_ptr;
  logic [CW-1:0]         r_count, w_free, w_count_next;
  logic [31:0]           r_cycle;
  logic [15:0]           r_drop, w_drop_next;
  logic [16:0]           w_drop_sum;
  logic [1:0]            w_drops;
  logic [ADDR_WIDTH-1:0] r_prev_iaddr;
  logic                  r_prev_valid;
  logic [SW-1:0]         r_stall_cnt, w_stall_next;
  logic                  w_halted, w_rf_ev, w_mem_ev, w_valid, w_pop;
  logic                  w_push_rf, w_push_mem, w_same, w_stall_hit, w_end_hit;
  entry_t                w_rf_entry, w_mem_entry, w_head;

  assign w_halted = (r_state == StHalted);
  assign w_rf_ev  = i_rf_wr & i_chan_en[0] & (i_rf_addr != 5'd0) & ~w_halted;
  assign w_mem_ev = i_mem_wr & i_chan_en[1] & ~w_halted;
  assign w_valid  = (r_count != '0);
  assign w_pop    = w_valid & i_trace_ready;

  // A same-cycle pop frees a slot; the register entry claims space before the memory entry.
  assign w_free       = CW'(DEPTH) - r_count + CW'(w_pop);
  assign w_push_rf    = w_rf_ev & (w_free != '0);
  assign w_push_mem   = w_mem_ev & (w_free > CW'(w_push_rf));
  assign w_mem_ptr    = r_wr_ptr + PW'(w_push_rf);
  assign w_count_next = r_count + CW'(w_push_rf) + CW'(w_push_mem) - CW'(w_pop);

  assign w_drops     = {1'b0, w_rf_ev & ~w_push_rf} + {1'b0, w_mem_ev & ~w_push_mem};
  assign w_drop_sum  = {1'b0, r_drop} + 17'(w_drops);
  assign w_drop_next = w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];

  assign w_rf_entry  = '{typ: 1'b0, addr: ADDR_WIDTH'(i_rf_addr), data: i_rf_data,
                         mask: 4'hF, cycle: r_cycle};
  assign w_mem_entry = '{typ: 1'b1, addr: i_mem_addr, data: i_mem_data,
                         mask: i_mem_mask, cycle: r_cycle};

  // The first cycle after reset has no previous PC to compare against.
  assign w_same       = r_prev_valid & (i_iaddr == r_prev_iaddr);
  assign w_stall_next = !w_same ? '0 :
                        (r_stall_cnt == SW'(STALL_LIMIT)) ? r_stall_cnt : r_stall_cnt + 1'b1;
  assign w_stall_hit  = w_same & (w_stall_next == SW'(STALL_LIMIT));
  assign w_end_hit    = (i_iaddr >= END_ADDR);

  always_comb begin
    w_state_next      = r_state;
    w_halt_cause_next = r_halt_cause;
    unique case (r_state)
      StRun: begin
        if (w_end_hit || w_stall_hit) begin
          w_state_next      = StHalted;
          w_halt_cause_next = {w_stall_hit, w_end_hit};
        end
      end
      StHalted: w_state_next = StHalted;
      default:  w_state_next = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StRun;
      r_halt_cause <= 2'b00;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_cycle      <= '0;
      r_drop       <= '0;
      r_prev_iaddr <= '0;
      r_prev_valid <= 1'b0;
      r_stall_cnt  <= '0;
    end else begin
      r_state      <= w_state_next;
      r_halt_cause <= w_halt_cause_next;
      r_wr_ptr     <= r_wr_ptr + PW'(w_push_rf) + PW'(w_push_mem);
      r_rd_ptr     <= r_rd_ptr + PW'(w_pop);
      r_count      <= w_count_next;
      r_cycle      <= r_cycle + 32'd1;
      r_drop       <= w_drop_next;
      r_prev_iaddr <= i_iaddr;
      r_prev_valid <= 1'b1;
      r_stall_cnt  <= w_stall_next;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_rf)  r_mem[r_wr_ptr]  <= w_rf_entry;
    if (w_push_mem) r_mem[w_mem_ptr] <= w_mem_entry;
  end

  assign w_head        = r_mem[r_rd_ptr];
  assign o_trace_valid = w_valid;
  assign o_trace_type  = w_valid ? w_head.typ   : 1'b0;
  assign o_trace_addr  = w_valid ? w_head.addr  : '0;
  assign o_trace_data  = w_valid ? w_head.data  : '0;
  assign o_trace_mask  = w_valid ? w_head.mask  : 4'h0;
  assign o_trace_cycle = w_valid ? w_head.cycle : 32'h0;
  assign o_drop_count  = r_drop;
  assign o_halt        = w_halted;
  assign o_halt_cause  = r_halt_cause;

endmodule

// File: tb/tb_asrv32_trace_monitor.sv
// Directed bench for asrv32_trace_monitor: expected trace entries are queued when stimulus is
// driven and compared against the FIFO head when popped.
module tb_asrv32_trace_monitor;

  localparam int DEPTH = 16;
  localparam int STALL = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_iaddr;
  logic        i_rf_wr;
  logic [4:0]  i_rf_addr;
  logic [31:0] i_rf_data;
  logic        i_mem_wr;
  logic [31:0] i_mem_addr;
  logic [31:0] i_mem_data;
  logic [3:0]  i_mem_mask;
  logic [1:0]  i_chan_en;
  logic        o_trace_valid;
  logic        i_trace_ready;
  logic        o_trace_type;
  logic [31:0] o_trace_addr;
  logic [31:0] o_trace_data;
  logic [3:0]  o_trace_mask;
  logic [31:0] o_trace_cycle;
  logic [15:0] o_drop_count;
  logic        o_halt;
  logic [1:0]  o_halt_cause;

  int           n_checks = 0;
  int           n_pass   = 0;
  int           cyc      = 0;
  bit           auto_pc  = 1'b1;
  logic [127:0] sb_q[$];

  asrv32_trace_monitor #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .DEPTH      (DEPTH),
    .END_ADDR   (32'h3C),
    .STALL_LIMIT(STALL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_iaddr      (i_iaddr),
    .i_rf_wr      (i_rf_wr),
    .i_rf_addr    (i_rf_addr),
    .i_rf_data    (i_rf_data),
    .i_mem_wr     (i_mem_wr),
    .i_mem_addr   (i_mem_addr),
    .i_mem_data   (i_mem_data),
    .i_mem_mask   (i_mem_mask),
    .i_chan_en    (i_chan_en),
    .o_trace_valid(o_trace_valid),
    .i_trace_ready(i_trace_ready),
    .o_trace_type (o_trace_type),
    .o_trace_addr (o_trace_addr),
    .o_trace_data (o_trace_data),
    .o_trace_mask (o_trace_mask),
    .o_trace_cycle(o_trace_cycle),
    .o_drop_count (o_drop_count),
    .o_halt       (o_halt),
    .o_halt_cause (o_halt_cause)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  function automatic logic [127:0] ent(logic t, logic [31:0] a, logic [31:0] d,
                                       logic [3:0] m, logic [31:0] c);
    return {27'b0, t, a, d, m, c};
  endfunction

  function automatic logic [127:0] head();
    return ent(o_trace_type, o_trace_addr, o_trace_data, o_trace_mask, o_trace_cycle);
  endfunction

  task automatic check(string tag, logic [127:0] obs, logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Inputs change 1 time unit after the edge, so outputs are also sampled there.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (auto_pc) i_iaddr = i_iaddr ^ 32'h4;
  endtask

  task automatic idle();
    i_rf_wr  = 1'b0;
    i_mem_wr = 1'b0;
  endtask

  task automatic drive_rf(logic [4:0] a, logic [31:0] d);
    i_rf_wr   = 1'b1;
    i_rf_addr = a;
    i_rf_data = d;
  endtask

  task automatic drive_mem(logic [31:0] a, logic [31:0] d, logic [3:0] m);
    i_mem_wr   = 1'b1;
    i_mem_addr = a;
    i_mem_data = d;
    i_mem_mask = m;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    i_trace_ready = 1'b0;
    step();
    step();
    check("reset_outputs",
          {o_trace_valid, o_drop_count, o_halt, o_halt_cause, head()}, '0);
    rst = 1'b0;
    cyc = 0;
    sb_q.delete();
  endtask

  task automatic compare_head(string tag);
    check({tag, "_valid"}, o_trace_valid, 1);
    if (sb_q.size() == 0) begin
      n_checks++;
      $error("FAIL %s: DUT entry %0h but scoreboard expected none", tag, head());
    end else begin
      check(tag, head(), sb_q.pop_front());
    end
  endtask

  initial begin
    rst = 1'b1;
    i_iaddr = '0;
    i_rf_addr = '0;
    i_rf_data = '0;
    i_mem_addr = '0;
    i_mem_data = '0;
    i_mem_mask = '0;
    i_chan_en = 2'b11;
    i_trace_ready = 1'b0;
    idle();

    do_reset();
    step(); step(); step();

    // Single register write, stamp equals cycles since release.
    drive_rf(5'd5, 32'h12345678);
    sb_q.push_back(ent(1'b0, 32'd5, 32'h12345678, 4'hF, 32'(cyc)));
    step();
    idle();
    check("t2_valid", o_trace_valid, 1);
    check("t2_type", o_trace_type, 0);
    check("t2_addr", o_trace_addr, 5);
    check("t2_data", o_trace_data, 32'h12345678);
    check("t2_mask", o_trace_mask, 4'hF);
    check("t2_cycle", o_trace_cycle, 3);
    compare_head("t2_head");
    i_trace_ready = 1'b1;
    step();
    i_trace_ready = 1'b0;
    check("t2_empty", o_trace_valid, 0);

    // Same-cycle register and memory writes.
    drive_rf(5'd1, 32'hA);
    drive_mem(32'h1000, 32'h55, 4'b0011);
    sb_q.push_back(ent(1'b0, 32'd1, 32'hA, 4'hF, 32'(cyc)));
    sb_q.push_back(ent(1'b1, 32'h1000, 32'h55, 4'b0011, 32'(cyc)));
    step();
    idle();
    i_trace_ready = 1'b1;
    compare_head("t3_rf");
    step();
    compare_head("t3_mem");
    step();
    i_trace_ready = 1'b0;
    check("t3_empty", o_trace_valid, 0);
    check("t3_payload_zero", head(), '0);

    // Overfill with ready low.
    for (int i = 0; i < DEPTH + 3; i++) begin
      drive_rf(5'(i % 31 + 1), 32'hA000 + 32'(i));
      if (i < DEPTH) sb_q.push_back(ent(1'b0, 32'(i % 31 + 1), 32'hA000 + 32'(i), 4'hF, 32'(cyc)));
      step();
    end
    idle();
    check("t4_drops", o_drop_count, 3);
    check("t4_valid", o_trace_valid, 1);
    drive_rf(5'd0, 32'hDEAD);
    step(); step();
    idle();
    i_chan_en = 2'b00;
    drive_rf(5'd9, 32'h99);
    drive_mem(32'h4000, 32'h44, 4'hF);
    step(); step();
    idle();
    i_chan_en = 2'b11;
    check("t4_no_extra_drops", o_drop_count, 3);

    // Full FIFO with simultaneous pop and a memory write.
    compare_head("t5_pop");
    i_trace_ready = 1'b1;
    drive_mem(32'h2000, 32'hBEEF, 4'b1000);
    sb_q.push_back(ent(1'b1, 32'h2000, 32'hBEEF, 4'b1000, 32'(cyc)));
    step();
    i_trace_ready = 1'b0;
    idle();
    check("t5_drops_same", o_drop_count, 3);
    drive_rf(5'd2, 32'h22);
    step();
    idle();
    check("t5_still_full", o_drop_count, 4);
    i_trace_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      compare_head($sformatf("t5_drain%0d", i));
      step();
    end
    i_trace_ready = 1'b0;
    check("t5_empty", o_trace_valid, 0);
    check("t5_sb_empty", sb_q.size(), 0);

    // Reset while holding an entry.
    drive_rf(5'd4, 32'h44);
    step();
    idle();
    check("mid_valid", o_trace_valid, 1);
    do_reset();

    // End-address halt.
    auto_pc = 1'b0;
    i_iaddr = 32'h38;
    step();
    check("t6a_pre_halt", o_halt, 0);
    i_iaddr = 32'h3C;
    step();
    check("t6a_halt", o_halt, 1);
    check("t6a_cause", o_halt_cause, 2'b01);
    drive_rf(5'd6, 32'h66);
    drive_mem(32'h5000, 32'h55, 4'hF);
    step();
    idle();
    check("t6a_no_capture", o_trace_valid, 0);
    check("t6a_no_drops", o_drop_count, 0);

    // PC-stall halt; captured entries still drain afterwards.
    i_iaddr = 32'h20;
    do_reset();
    drive_rf(5'd3, 32'h33);
    sb_q.push_back(ent(1'b0, 32'd3, 32'h33, 4'hF, 32'(cyc)));
    step();
    idle();
    drive_mem(32'h3000, 32'h77, 4'hF);
    sb_q.push_back(ent(1'b1, 32'h3000, 32'h77, 4'hF, 32'(cyc)));
    step();
    idle();
    repeat (STALL - 2) step();
    check("t6b_pre_halt", o_halt, 0);
    step();
    check("t6b_halt", o_halt, 1);
    check("t6b_cause", o_halt_cause, 2'b10);
    drive_rf(5'd7, 32'h77);
    drive_mem(32'h6000, 32'h66, 4'hF);
    step();
    idle();
    check("t6b_no_drops", o_drop_count, 0);
    i_trace_ready = 1'b1;
    compare_head("t6b_drain0");
    step();
    compare_head("t6b_drain1");
    step();
    i_trace_ready = 1'b0;
    check("t6b_empty", o_trace_valid, 0);
    check("t6b_halt_sticky", o_halt, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
